mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage that sits between the EX/MEM register and the MEM/WB register.
- Performs data-memory loads and stores against an internal word-addressed memory with a configurable multi-cycle access latency.
- Asserts stall to freeze the upstream pipeline while an access is in flight.
- Feeds the MEM/WB register with either the completed instruction or a bubble.

Parameters:
- LEN_WORD, 32, data/address word width
- LEN_REG_FILE_ADDR, 5, register-file address width
- MEM_DEPTH, 256, number of words in data memory; power of 2
- MEM_LATENCY, 2, stall cycles per memory access; must be >= 1

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- ex_alu_out  input  LEN_WORD  ALU result / byte address from EX/MEM
- ex_write_data  input  LEN_WORD  store data from EX/MEM
- ex_write_reg  input  LEN_REG_FILE_ADDR  destination register
- ex_mem_read  input  1  load request
- ex_mem_write  input  1  store request
- ex_reg_write  input  1  register write-back enable
- ex_mem_to_reg  input  1  write-back select (memory data)
- read_data_mem  output  LEN_WORD  load data to MEM/WB
- alu_out  output  LEN_WORD  ALU result to MEM/WB
- write_reg  output  LEN_REG_FILE_ADDR  destination to MEM/WB
- mem_read  output  1  to MEM/WB
- reg_write  output  1  to MEM/WB
- mem_to_reg  output  1  to MEM/WB
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- misaligned  output  1  1-cycle flag: access with address bits [1:0] != 0 was dropped

Behaviour:
- Memory is a synchronous array. Index = ex_alu_out[log2(MEM_DEPTH)+1:2], so addresses wrap modulo MEM_DEPTH words. Contents are not cleared by reset.
- Access = ex_mem_read | ex_mem_write. If both are set, the instruction is treated as a store: mem_read output 0 and read_data_mem 0 in DONE.
- FSM states: IDLE, BUSY, DONE. Internal registers: cnt, rdata_q, and latched copies of all ex_* inputs.
- IDLE, no access: outputs combinationally equal the corresponding ex_* inputs; read_data_mem=0; stall=0.
- IDLE, access with ex_alu_out[1:0]!=0:
  - No memory operation; misaligned=1 and stall=0.
  - Outputs are a bubble: reg_write=0, mem_read=0, mem_to_reg=0, and all data outputs 0.
  - State stays IDLE.
- IDLE, aligned access:
  - Latch all ex_* inputs; stall=1; outputs are a bubble.
  - If MEM_LATENCY==1: perform the memory op at this edge and go to DONE.
  - Otherwise: go to BUSY with cnt=MEM_LATENCY-2.
- BUSY: stall=1; outputs are a bubble; ex_* inputs are ignored (the latched copy is used).
  - If cnt==0: perform the memory op at this edge (store writes latched data; load captures into rdata_q) and go to DONE.
  - Otherwise: cnt decrements.
- DONE:
  - stall=0; outputs come from the latched copy; read_data_mem=rdata_q for loads, 0 for stores.
  - Next state is IDLE. EX/MEM advances at the end of this cycle.
- Net effect: an aligned access asserts stall for exactly MEM_LATENCY consecutive cycles, and the instruction reaches MEM/WB at the edge ending DONE.
- Back-to-back accesses: the next access is detected in the IDLE cycle after DONE. There is no bubble-free overlap.
- Reset (any state, including mid-access):
  - state=IDLE, cnt=0, rdata_q=0, latched copies=0.
  - A store not yet committed is never written.
  - After reset: stall=0, misaligned=0, outputs follow ex_* per IDLE rules.

Test Plan:
- MEM_LATENCY=2. Store 0xDEADBEEF at addr 0x10, then load from 0x10 → stall high exactly 2 cycles per access; load DONE shows read_data_mem=0xDEADBEEF and mem_to_reg/reg_write equal to the inputs; bubble cycles show reg_write=0.
- ALU op (no access), ex_alu_out=0x1234, ex_reg_write=1, ex_write_reg=7 → same-cycle pass-through, stall=0, read_data_mem=0.
- Load from 0x13 → misaligned=1 for 1 cycle, stall=0, reg_write=0, no memory change (a later aligned load of 0x10 still returns the old value).
- Reset asserted during the second BUSY cycle of a store (MEM_LATENCY=3) → stall=0 the next cycle; a later load of that address returns the previous contents.
- Address wrap, MEM_DEPTH=256: store 0xA5A5A5A5 to 0x400, load 0x000 → read_data_mem=0xA5A5A5A5. Both read and write set → treated as store, mem_read output 0.
- ex_* inputs changed during BUSY → DONE outputs still reflect the values latched at acceptance.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a multi-cycle word-addressed data memory and upstream stall.
module mem_stage #(
  parameter int LEN_WORD          = 32,
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int MEM_DEPTH         = 256,
  parameter int MEM_LATENCY       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEN_WORD-1:0]          ex_alu_out,
  input  logic [LEN_WORD-1:0]          ex_write_data,
  input  logic [LEN_REG_FILE_ADDR-1:0] ex_write_reg,
  input  logic                         ex_mem_read,
  input  logic                         ex_mem_write,
  input  logic                         ex_reg_write,
  input  logic                         ex_mem_to_reg,
  output logic [LEN_WORD-1:0]          read_data_mem,
  output logic [LEN_WORD-1:0]          alu_out,
  output logic [LEN_REG_FILE_ADDR-1:0] write_reg,
  output logic                         mem_read,
  output logic                         reg_write,
  output logic                         mem_to_reg,
  output logic                         stall,
  output logic                         misaligned
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = (MEM_LATENCY > 1) ? CW'(MEM_LATENCY - 2) : '0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LEN_WORD-1:0] rdata_q, rdata_d, alu_out_q, alu_out_d, write_data_q, write_data_d;
  logic [LEN_REG_FILE_ADDR-1:0] write_reg_q, write_reg_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [LEN_WORD-1:0] mem [MEM_DEPTH];
  logic in_idle, access, go, commit, op_wr, mem_we, pass, done, load_done;
  logic [AW-1:0] idx;
  logic [LEN_WORD-1:0] op_wdata;
  always_comb begin
    in_idle      = state_q == IDLE;
    access       = ex_mem_read | ex_mem_write;
    go           = in_idle && access && ex_alu_out[1:0] == 2'b00;
    misaligned   = in_idle && access && ex_alu_out[1:0] != 2'b00;
    commit       = (state_q == BUSY && cnt_q == '0) || (go && MEM_LATENCY == 1);
    // With single-cycle latency the op happens at acceptance, straight from the ex_* inputs
    idx          = in_idle ? ex_alu_out[AW+1:2] : alu_out_q[AW+1:2];
    op_wdata     = in_idle ? ex_write_data : write_data_q;
    op_wr        = in_idle ? ex_mem_write : mem_write_q;
    mem_we       = commit && op_wr && !reset;
    rdata_d      = (commit && !op_wr) ? mem[idx] : rdata_q;
    state_d      = state_q == DONE ? IDLE :
                   state_q == BUSY ? (cnt_q == '0 ? DONE : BUSY) :
                   go ? (MEM_LATENCY == 1 ? DONE : BUSY) : IDLE;
    cnt_d        = go ? CNT_INIT : (state_q == BUSY && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    alu_out_d    = go ? ex_alu_out : alu_out_q;
    write_data_d = go ? ex_write_data : write_data_q;
    write_reg_d  = go ? ex_write_reg : write_reg_q;
    mem_read_d   = go ? ex_mem_read : mem_read_q;
    mem_write_d  = go ? ex_mem_write : mem_write_q;
    reg_write_d  = go ? ex_reg_write : reg_write_q;
    mem_to_reg_d = go ? ex_mem_to_reg : mem_to_reg_q;
    pass         = in_idle && !access;
    done         = state_q == DONE;
    load_done    = done && mem_read_q && !mem_write_q;
    stall        = go || state_q == BUSY;
    alu_out      = pass ? ex_alu_out : done ? alu_out_q : '0;
    write_reg    = pass ? ex_write_reg : done ? write_reg_q : '0;
    reg_write    = pass ? ex_reg_write : done && reg_write_q;
    mem_to_reg   = pass ? ex_mem_to_reg : done && mem_to_reg_q;
    mem_read     = load_done;
    read_data_mem = load_done ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= op_wdata;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at MEM_LATENCY=2 and MEM_LATENCY=3.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst2, rst3;
  logic [31:0] a_in, d_in;
  logic [4:0] r_in;
  logic mr_in, mw_in, rw_in, mtr_in;
  logic [31:0] rd2, alu2, rd3, alu3;
  logic [4:0] wreg2, wreg3;
  logic mrd2, rw2, m2r2, st2, mis2, mrd3, rw3, m2r3, st3, mis3;
  int n_cmp = 0;
  int n_err = 0;
  int ns;
  logic bub;
  always #5 clk = ~clk;
  mem_stage #(.MEM_LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst2), .ex_alu_out(a_in), .ex_write_data(d_in), .ex_write_reg(r_in),
    .ex_mem_read(mr_in), .ex_mem_write(mw_in), .ex_reg_write(rw_in), .ex_mem_to_reg(mtr_in),
    .read_data_mem(rd2), .alu_out(alu2), .write_reg(wreg2), .mem_read(mrd2),
    .reg_write(rw2), .mem_to_reg(m2r2), .stall(st2), .misaligned(mis2)
  );
  mem_stage #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst3), .ex_alu_out(a_in), .ex_write_data(d_in), .ex_write_reg(r_in),
    .ex_mem_read(mr_in), .ex_mem_write(mw_in), .ex_reg_write(rw_in), .ex_mem_to_reg(mtr_in),
    .read_data_mem(rd3), .alu_out(alu3), .write_reg(wreg3), .mem_read(mrd3),
    .reg_write(rw3), .mem_to_reg(m2r3), .stall(st3), .misaligned(mis3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic mr, input logic mw, input logic rw, input logic mtr);
    a_in = a; d_in = d; r_in = r; mr_in = mr; mw_in = mw; rw_in = rw; mtr_in = mtr;
  endtask
  // Counts stall cycles of the chosen instance and ORs reg_write over them; returns at DONE negedge
  task automatic acc(input bit l3, output int n, output logic b);
    n = 0;
    b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(l3 ? st3 : st2)) break;
      n++;
      b |= l3 ? rw3 : rw2;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst2 = 1'b1;
    rst3 = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_stall", st2, 0);
    chk("rst_mis", mis2, 0);
    chk("rst_rd", rd2, 0);
    tick;
    drive(32'h10, 32'hDEADBEEF, 0, 0, 1, 0, 0);
    acc(0, ns, bub);
    chk("st_stall", ns, 2);
    chk("st_rd", rd2, 0);
    tick;
    drive(32'h10, 0, 3, 1, 0, 1, 1);
    acc(0, ns, bub);
    chk("ld_stall", ns, 2);
    chk("ld_bubble_rw", bub, 0);
    chk("ld_data", rd2, 32'hDEADBEEF);
    chk("ld_m2r", m2r2, 1);
    chk("ld_rw", rw2, 1);
    chk("ld_wreg", wreg2, 3);
    chk("ld_mrd", mrd2, 1);
    chk("ld_alu", alu2, 32'h10);
    tick;
    drive(32'h1234, 0, 7, 0, 0, 1, 0);
    @(negedge clk);
    chk("alu_out", alu2, 32'h1234);
    chk("alu_rw", rw2, 1);
    chk("alu_wreg", wreg2, 7);
    chk("alu_stall", st2, 0);
    chk("alu_rd", rd2, 0);
    tick;
    drive(32'h13, 0, 4, 1, 0, 1, 1);
    @(negedge clk);
    chk("mis_flag", mis2, 1);
    chk("mis_stall", st2, 0);
    chk("mis_rw", rw2, 0);
    chk("mis_alu", alu2, 0);
    chk("mis_wreg", wreg2, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mis_clear", mis2, 0);
    tick;
    drive(32'h12, 32'h11111111, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("mis_st_flag", mis2, 1);
    chk("mis_st_stall", st2, 0);
    tick;
    drive(32'h10, 0, 3, 1, 0, 1, 1);
    acc(0, ns, bub);
    chk("mis_ld_data", rd2, 32'hDEADBEEF);
    tick;
    drive(32'h400, 32'hA5A5A5A5, 0, 1, 1, 0, 0);
    acc(0, ns, bub);
    chk("rw_stall", ns, 2);
    chk("rw_mrd", mrd2, 0);
    chk("rw_rd", rd2, 0);
    tick;
    drive(32'h0, 0, 5, 1, 0, 1, 1);
    acc(0, ns, bub);
    chk("wrap_data", rd2, 32'hA5A5A5A5);
    tick;
    drive(32'h10, 0, 9, 1, 0, 1, 1);
    @(negedge clk);
    chk("lat_stall0", st2, 1);
    tick;
    drive(32'h44, 32'hFFFFFFFF, 2, 0, 1, 0, 0);
    @(negedge clk);
    chk("lat_stall1", st2, 1);
    tick;
    @(negedge clk);
    chk("lat_done_stall", st2, 0);
    chk("lat_alu", alu2, 32'h10);
    chk("lat_wreg", wreg2, 9);
    chk("lat_rw", rw2, 1);
    chk("lat_data", rd2, 32'hDEADBEEF);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst2 = 1'b1;
    rst3 = 1'b0;
    tick;
    drive(32'h20, 32'h0BADF00D, 0, 0, 1, 0, 0);
    acc(1, ns, bub);
    chk("l3_st_stall", ns, 3);
    tick;
    drive(32'h20, 32'h12345678, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("l3_rs_stall0", st3, 1);
    tick;
    tick;
    @(negedge clk);
    chk("l3_rs_stall2", st3, 1);
    rst3 = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    rst3 = 1'b0;
    @(negedge clk);
    chk("l3_post_rst_stall", st3, 0);
    chk("l3_post_rst_mis", mis3, 0);
    tick;
    drive(32'h20, 0, 1, 1, 0, 1, 1);
    acc(1, ns, bub);
    chk("l3_ld_stall", ns, 3);
    chk("l3_ld_data", rd3, 32'h0BADF00D);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
